inexrecur_writeback: RTL

Write-back stage of the InexRecur accelerator. It takes the per-iteration result of the execute stage and commits it to the two register files that the fetch side reads: the state entry of the current parameter, and newly spawned recursion calls. The current entry's state (position, termination) is written to `regfile_state`. Each new call `{i,z,k,l}` is appended to `regfile_InexRecur` at a tail pointer, together with a fresh state entry. It sits between `ex` and the write ports of both register files, and reports completion and table overflow.

---
 rtl/inexrecur_writeback.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/inexrecur_writeback.sv
// inexrecur_writeback: commit stage of the InexRecur accelerator.
// Takes one execute result per handshake, writes the executed entry's state
// word, then optionally appends a spawned recursion call (and a zeroed state
// entry for it) at the tail of the call table.
//
// Handshake: a result is transferred on a rising edge where wb_valid_i and
// wb_ready_o are both high; wb_ready_o is high only in IDLE outside reset,
// and start_i in that same cycle wins so the result is not taken.
//
// All write enables, addresses and data are flops loaded one edge ahead, so
// each enable is a single-cycle registered pulse; enables are masked by rst
// so nothing is written while reset is asserted.
module inexrecur_writeback #(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int INIT_TAIL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [ADDR_W-1:0] current_addr_i,
  input  logic              en_new_position_i,
  input  logic [4:0]        new_position_i,
  input  logic              over_1_i,
  input  logic              over_2_i,
  input  logic              new_call_i,
  input  logic [7:0]        i_new_i,
  input  logic [7:0]        z_new_i,
  input  logic [7:0]        k_new_i,
  input  logic [7:0]        l_new_i,
  input  logic              finish_i,
  output logic              we_reg_InexRecur_o,
  output logic [ADDR_W-1:0] w_reg_InexRecur_addr_o,
  output logic [31:0]       w_reg_InexRecur_data_o,
  output logic              we_reg_state_o,
  output logic [ADDR_W-1:0] w_reg_state_addr_o,
  output logic [17:0]       w_reg_state_data_o,
  output logic [ADDR_W-1:0] tail_addr_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_STATE = 2'd1,
    WR_CALL  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TAIL_INIT = ADDR_W'(INIT_TAIL);

  state_t state_q, state_d;

  // Fields of the accepted result still needed after the state write.
  logic        lat_over_1, lat_over_2, lat_new_call, lat_finish;
  logic [31:0] lat_call;

  logic [ADDR_W-1:0] tail_q, tail_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              accept;

  logic              we_state_q, we_state_d;
  logic [ADDR_W-1:0] state_addr_q, state_addr_d;
  logic [17:0]       state_data_q, state_data_d;
  logic              we_call_q, we_call_d;
  logic [ADDR_W-1:0] call_addr_q, call_addr_d;
  logic [31:0]       call_data_q, call_data_d;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, next-cycle write port contents and tail/flag updates.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    tail_d       = tail_q;
    full_d       = full_q;
    ovf_d        = ovf_q;
    we_state_d   = 1'b0;
    state_addr_d = '0;
    state_data_d = '0;
    we_call_d    = 1'b0;
    call_addr_d  = '0;
    call_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tail_d = TAIL_INIT;
          full_d = 1'b0;
          ovf_d  = 1'b0;
        end else if (wb_valid_i && wb_ready_o) begin
          accept  = 1'b1;
          state_d = WR_STATE;
          if (en_new_position_i || over_1_i || over_2_i) begin
            we_state_d   = 1'b1;
            state_addr_d = current_addr_i;
            state_data_d = {over_1_i | over_2_i, over_2_i, over_1_i,
                            new_position_i, 10'b0};
          end
        end
      end
      WR_STATE: begin
        // A terminated entry never spawns; its call is silently dropped.
        if (lat_new_call && !(lat_over_1 || lat_over_2)) begin
          state_d = WR_CALL;
          if (!full_q) begin
            we_call_d    = 1'b1;
            call_addr_d  = tail_q;
            call_data_d  = lat_call;
            we_state_d   = 1'b1;
            state_addr_d = tail_q;
            state_data_d = '0;
          end
        end else if (lat_finish) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      WR_CALL: begin
        // Tail saturates at the last slot; full marks that slot as used.
        if (!full_q) begin
          if (tail_q == LAST_ADDR) full_d = 1'b1;
          else                     tail_d = tail_q + ADDR_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
        state_d = lat_finish ? DONE : IDLE;
      end
      DONE: begin
        if (start_i) begin
          tail_d  = TAIL_INIT;
          full_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched result, tail/flags and write port flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_over_1   <= 1'b0;
      lat_over_2   <= 1'b0;
      lat_new_call <= 1'b0;
      lat_finish   <= 1'b0;
      lat_call     <= '0;
      tail_q       <= TAIL_INIT;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      we_state_q   <= 1'b0;
      state_addr_q <= '0;
      state_data_q <= '0;
      we_call_q    <= 1'b0;
      call_addr_q  <= '0;
      call_data_q  <= '0;
    end else begin
      if (accept) begin
        lat_over_1   <= over_1_i;
        lat_over_2   <= over_2_i;
        lat_new_call <= new_call_i;
        lat_finish   <= finish_i;
        lat_call     <= {i_new_i, z_new_i, k_new_i, l_new_i};
      end
      tail_q       <= tail_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      we_state_q   <= we_state_d;
      state_addr_q <= state_addr_d;
      state_data_q <= state_data_d;
      we_call_q    <= we_call_d;
      call_addr_q  <= call_addr_d;
      call_data_q  <= call_data_d;
    end
  end

  // Output drive; enables are masked during reset so no write escapes.
  always_comb begin
    wb_ready_o             = (state_q == IDLE) && !rst;
    we_reg_state_o         = we_state_q && !rst;
    w_reg_state_addr_o     = state_addr_q;
    w_reg_state_data_o     = state_data_q;
    we_reg_InexRecur_o     = we_call_q && !rst;
    w_reg_InexRecur_addr_o = call_addr_q;
    w_reg_InexRecur_data_o = call_data_q;
    tail_addr_o            = tail_q;
    full_o                 = full_q;
    overflow_o             = ovf_q;
    done_o                 = (state_q == DONE);
    dbg_state_o            = state_q;
  end

endmodule
